// File: rtl/aplic_regif_arb_pkg.sv
// Shared types and widths for the APLIC configuration-port arbiter.
package aplic_regif_arb_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/aplic_rr_picker.sv
// Round-robin search: first set request bit at or after ptr_i, wrapping past the top index.
module aplic_rr_picker #(
  parameter int N = 2
) (
  input  logic [N-1:0]         valid_i,
  input  logic [$clog2(N)-1:0] ptr_i,
  output logic [$clog2(N)-1:0] idx_o,
  output logic                 any_o
);

  localparam int IDX_W = $clog2(N);

  logic [IDX_W:0] pos;

  // Walk offsets from farthest to nearest so the nearest hit is the one that sticks.
  always_comb begin
    idx_o = '0;
    any_o = 1'b0;
    pos   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, ptr_i} + (IDX_W + 1)'(k);
      if (pos >= (IDX_W + 1)'(N)) begin
        pos = pos - (IDX_W + 1)'(N);
      end
      if (valid_i[pos[IDX_W-1:0]]) begin
        idx_o = pos[IDX_W-1:0];
        any_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/aplic_regif_arbiter.sv
// Round-robin arbiter sharing the APLIC configuration port among NR_MASTERS requesters,
// with a per-access timeout that answers with an error when the APLIC never acknowledges.
module aplic_regif_arbiter
  import aplic_regif_arb_pkg::*;
#(
  parameter int NR_MASTERS     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                i_clk,
  input  logic                                i_rst,
  input  logic [NR_MASTERS-1:0][ADDR_W-1:0]   i_m_addr,
  input  logic [NR_MASTERS-1:0]               i_m_write,
  input  logic [NR_MASTERS-1:0][DATA_W-1:0]   i_m_wdata,
  input  logic [NR_MASTERS-1:0][STRB_W-1:0]   i_m_wstrb,
  input  logic [NR_MASTERS-1:0]               i_m_valid,
  output logic [NR_MASTERS-1:0][DATA_W-1:0]   o_m_rdata,
  output logic [NR_MASTERS-1:0]               o_m_error,
  output logic [NR_MASTERS-1:0]               o_m_ready,
  output logic [ADDR_W-1:0]                   o_s_addr,
  output logic                                o_s_write,
  output logic [DATA_W-1:0]                   o_s_wdata,
  output logic [STRB_W-1:0]                   o_s_wstrb,
  output logic                                o_s_valid,
  input  logic [DATA_W-1:0]                   i_s_rdata,
  input  logic                                i_s_error,
  input  logic                                i_s_ready
);

  localparam int IDX_W = $clog2(NR_MASTERS);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [IDX_W-1:0] ptr_after_grant;
  logic             timeout_hit;

  aplic_rr_picker #(.N(NR_MASTERS)) u_picker (
    .valid_i (i_m_valid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  assign ptr_after_grant = (grant_q == IDX_W'(NR_MASTERS - 1)) ? '0 : grant_q + IDX_W'(1);
  assign timeout_hit     = (TIMEOUT_CYCLES != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    cnt_d     = cnt_q;
    o_s_addr  = '0;
    o_s_write = 1'b0;
    o_s_wdata = '0;
    o_s_wstrb = '0;
    o_s_valid = 1'b0;
    o_m_rdata = '0;
    o_m_error = '0;
    o_m_ready = '0;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = BUSY;
        end
      end
      BUSY: begin
        o_s_addr  = i_m_addr[grant_q];
        o_s_write = i_m_write[grant_q];
        o_s_wdata = i_m_wdata[grant_q];
        o_s_wstrb = i_m_wstrb[grant_q];
        // A master that abandons its request gets no response, even if the timeout is due.
        if (!i_m_valid[grant_q]) begin
          state_d  = IDLE;
          rr_ptr_d = ptr_after_grant;
        end else if (timeout_hit) begin
          o_m_ready[grant_q] = 1'b1;
          o_m_error[grant_q] = 1'b1;
          state_d            = IDLE;
          rr_ptr_d           = ptr_after_grant;
        end else begin
          o_s_valid = 1'b1;
          if (i_s_ready) begin
            o_m_ready[grant_q] = 1'b1;
            o_m_error[grant_q] = i_s_error;
            o_m_rdata[grant_q] = i_s_rdata;
            state_d            = IDLE;
            rr_ptr_d           = ptr_after_grant;
          end else if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (i_rst) begin
      o_s_addr  = '0;
      o_s_write = 1'b0;
      o_s_wdata = '0;
      o_s_wstrb = '0;
      o_s_valid = 1'b0;
      o_m_rdata = '0;
      o_m_error = '0;
      o_m_ready = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

endmodule

// File: tb/tb_aplic_regif_arbiter.sv
// Cycle-by-cycle vector table plus a timeout-latency sequence for the APLIC config-port arbiter.
module tb_aplic_regif_arbiter;

  typedef struct {
    logic        rst;
    logic [1:0]  mv;
    logic        sr;
    logic [31:0] srd;
    logic        se;
    logic        cmp_s;
    logic        sv;
    logic [31:0] sa;
    logic        sw;
    logic [31:0] swd;
    logic [3:0]  sst;
    logic [1:0]  mr;
    logic [1:0]  me;
    logic [31:0] rd0;
    logic [31:0] rd1;
  } vec_t;

  typedef struct {
    int          lat;
    logic        err;
    logic [31:0] rd;
    logic        sv;
  } rsp_t;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic [1:0][31:0]  i_m_addr;
  logic [1:0]        i_m_write;
  logic [1:0][31:0]  i_m_wdata;
  logic [1:0][3:0]   i_m_wstrb;
  logic [1:0]        i_m_valid = '0;
  logic [1:0][31:0]  o_m_rdata;
  logic [1:0]        o_m_error;
  logic [1:0]        o_m_ready;
  logic [31:0]       o_s_addr;
  logic              o_s_write;
  logic [31:0]       o_s_wdata;
  logic [3:0]        o_s_wstrb;
  logic              o_s_valid;
  logic [31:0]       i_s_rdata = '0;
  logic              i_s_error = 1'b0;
  logic              i_s_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_addr  [2] = '{32'h0000_4000, 32'h0000_4004};
  logic        m_write [2] = '{1'b0, 1'b1};
  logic [31:0] m_wdata [2] = '{32'h0, 32'h1};
  logic [3:0]  m_wstrb [2] = '{4'h0, 4'hF};

  vec_t vecs[$];
  vec_t exp_q[$];
  rsp_t rsp_q[$];

  aplic_regif_arbiter #(.NR_MASTERS(2), .TIMEOUT_CYCLES(4)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_m_addr  (i_m_addr),
    .i_m_write (i_m_write),
    .i_m_wdata (i_m_wdata),
    .i_m_wstrb (i_m_wstrb),
    .i_m_valid (i_m_valid),
    .o_m_rdata (o_m_rdata),
    .o_m_error (o_m_error),
    .o_m_ready (o_m_ready),
    .o_s_addr  (o_s_addr),
    .o_s_write (o_s_write),
    .o_s_wdata (o_s_wdata),
    .o_s_wstrb (o_s_wstrb),
    .o_s_valid (o_s_valid),
    .i_s_rdata (i_s_rdata),
    .i_s_error (i_s_error),
    .i_s_ready (i_s_ready)
  );

  always #5 i_clk = ~i_clk;

  // g < 0: arbiter idle (or in reset); otherwise master g owns the bus this cycle.
  function automatic vec_t row(bit rst, bit [1:0] mv, bit sr, bit [31:0] srd, bit se,
                               int g, bit sv, bit [1:0] mr, bit [1:0] me, bit [31:0] rd);
    vec_t v;
    v.rst = rst; v.mv = mv; v.sr = sr; v.srd = srd; v.se = se;
    v.sv = sv; v.mr = mr; v.me = me;
    v.cmp_s = sv | rst;
    v.sa = '0; v.sw = 1'b0; v.swd = '0; v.sst = '0;
    v.rd0 = '0; v.rd1 = '0;
    if (g >= 0) begin
      v.sa = m_addr[g]; v.sw = m_write[g]; v.swd = m_wdata[g]; v.sst = m_wstrb[g];
      if (g == 0) v.rd0 = rd; else v.rd1 = rd;
    end
    return v;
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s row %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic check_row(int i, vec_t e);
    chk("s_valid", i, 32'(o_s_valid), 32'(e.sv));
    chk("m_ready", i, 32'(o_m_ready), 32'(e.mr));
    chk("m_error", i, 32'(o_m_error), 32'(e.me));
    chk("m0_rdata", i, o_m_rdata[0], e.rd0);
    chk("m1_rdata", i, o_m_rdata[1], e.rd1);
    if (e.cmp_s) begin
      chk("s_addr", i, o_s_addr, e.sa);
      chk("s_write", i, 32'(o_s_write), 32'(e.sw));
      chk("s_wdata", i, o_s_wdata, e.swd);
      chk("s_wstrb", i, 32'(o_s_wstrb), 32'(e.sst));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t e;
    rsp_t r;
    int   lat;
    logic got_err, got_sv;
    logic [31:0] got_rd;

    for (int m = 0; m < 2; m++) begin
      i_m_addr[m]  = m_addr[m];
      i_m_write[m] = m_write[m];
      i_m_wdata[m] = m_wdata[m];
      i_m_wstrb[m] = m_wstrb[m];
    end

    // reset
    vecs.push_back(row(1, 2'b00, 0, 32'h0,         0, -1, 0, 2'b00, 2'b00, 32'h0));
    vecs.push_back(row(1, 2'b11, 1, 32'h1234,      0, -1, 0, 2'b00, 2'b00, 32'h0));
    // single read, then rr_ptr=1 favours m1
    vecs.push_back(row(0, 2'b01, 1, 32'hDEADBEEF,  0, -1, 0, 2'b00, 2'b00, 32'h0));
    vecs.push_back(row(0, 2'b01, 1, 32'hDEADBEEF,  0,  0, 1, 2'b01, 2'b00, 32'hDEADBEEF));
    vecs.push_back(row(0, 2'b11, 1, 32'h11111111,  0, -1, 0, 2'b00, 2'b00, 32'h0));
    vecs.push_back(row(0, 2'b11, 1, 32'h11111111,  0,  1, 1, 2'b10, 2'b00, 32'h11111111));
    // contention: m0 at cycle 1, m1 write at cycle 3
    vecs.push_back(row(0, 2'b11, 1, 32'h22222222,  0, -1, 0, 2'b00, 2'b00, 32'h0));
    vecs.push_back(row(0, 2'b11, 1, 32'h22222222,  0,  0, 1, 2'b01, 2'b00, 32'h22222222));
    vecs.push_back(row(0, 2'b10, 1, 32'h33333333,  0, -1, 0, 2'b00, 2'b00, 32'h0));
    vecs.push_back(row(0, 2'b10, 1, 32'h33333333,  0,  1, 1, 2'b10, 2'b00, 32'h33333333));
    // fairness with continuous requests; error passthrough on m1
    vecs.push_back(row(0, 2'b11, 1, 32'h44444444,  0, -1, 0, 2'b00, 2'b00, 32'h0));
    vecs.push_back(row(0, 2'b11, 1, 32'h44444444,  0,  0, 1, 2'b01, 2'b00, 32'h44444444));
    vecs.push_back(row(0, 2'b11, 1, 32'h55555555,  1, -1, 0, 2'b00, 2'b00, 32'h0));
    vecs.push_back(row(0, 2'b11, 1, 32'h55555555,  1,  1, 1, 2'b10, 2'b10, 32'h55555555));
    vecs.push_back(row(0, 2'b11, 1, 32'h66666666,  0, -1, 0, 2'b00, 2'b00, 32'h0));
    vecs.push_back(row(0, 2'b11, 1, 32'h66666666,  0,  0, 1, 2'b01, 2'b00, 32'h66666666));
    // timeout after 4 busy cycles
    vecs.push_back(row(0, 2'b01, 0, 32'hBAD0BAD0,  0, -1, 0, 2'b00, 2'b00, 32'h0));
    vecs.push_back(row(0, 2'b01, 0, 32'hBAD0BAD0,  0,  0, 1, 2'b00, 2'b00, 32'h0));
    vecs.push_back(row(0, 2'b01, 0, 32'hBAD0BAD0,  0,  0, 1, 2'b00, 2'b00, 32'h0));
    vecs.push_back(row(0, 2'b01, 0, 32'hBAD0BAD0,  0,  0, 1, 2'b00, 2'b00, 32'h0));
    vecs.push_back(row(0, 2'b01, 0, 32'hBAD0BAD0,  0,  0, 0, 2'b01, 2'b01, 32'h0));
    // abort by m1, then m0 served
    vecs.push_back(row(0, 2'b11, 0, 32'h0,         0, -1, 0, 2'b00, 2'b00, 32'h0));
    vecs.push_back(row(0, 2'b01, 0, 32'h0,         0,  1, 0, 2'b00, 2'b00, 32'h0));
    vecs.push_back(row(0, 2'b01, 1, 32'h0A0A0A0A,  0, -1, 0, 2'b00, 2'b00, 32'h0));
    vecs.push_back(row(0, 2'b01, 1, 32'h0A0A0A0A,  0,  0, 1, 2'b01, 2'b00, 32'h0A0A0A0A));
    // reset in the second cycle of a stalled m1 access; rr_ptr back to 0
    vecs.push_back(row(0, 2'b10, 0, 32'h0,         0, -1, 0, 2'b00, 2'b00, 32'h0));
    vecs.push_back(row(0, 2'b10, 0, 32'h0,         0,  1, 1, 2'b00, 2'b00, 32'h0));
    vecs.push_back(row(1, 2'b10, 1, 32'h0,         0, -1, 0, 2'b00, 2'b00, 32'h0));
    vecs.push_back(row(0, 2'b11, 1, 32'h77777777,  0, -1, 0, 2'b00, 2'b00, 32'h0));
    vecs.push_back(row(0, 2'b11, 1, 32'h77777777,  0,  0, 1, 2'b01, 2'b00, 32'h77777777));
    vecs.push_back(row(0, 2'b00, 0, 32'h0,         0, -1, 0, 2'b00, 2'b00, 32'h0));

    foreach (vecs[i]) begin
      @(posedge i_clk);
      #1;
      i_rst     = vecs[i].rst;
      i_m_valid = vecs[i].mv;
      i_s_ready = vecs[i].sr;
      i_s_rdata = vecs[i].srd;
      i_s_error = vecs[i].se;
      exp_q.push_back(vecs[i]);
      @(negedge i_clk);
      e = exp_q.pop_front();
      check_row(i, e);
    end

    // Timeout latency measured from the request cycle, APLIC silent.
    @(posedge i_clk);
    #1;
    i_m_valid = 2'b01;
    i_s_ready = 1'b0;
    i_s_rdata = 32'hCAFE_F00D;
    i_s_error = 1'b0;
    rsp_q.push_back('{lat: 4, err: 1'b1, rd: 32'h0, sv: 1'b0});
    lat = -1; got_err = 1'b0; got_rd = '0; got_sv = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      if (o_m_ready[0] === 1'b1) begin
        lat = c; got_err = o_m_error[0]; got_rd = o_m_rdata[0]; got_sv = o_s_valid;
        break;
      end
    end
    r = rsp_q.pop_front();
    chk("timeout_latency", 0, 32'(lat), 32'(r.lat));
    chk("timeout_error", 0, 32'(got_err), 32'(r.err));
    chk("timeout_rdata", 0, got_rd, r.rd);
    chk("timeout_s_valid", 0, 32'(got_sv), 32'(r.sv));

    @(posedge i_clk);
    #1;
    i_m_valid = '0;
    repeat (2) @(posedge i_clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
